// File: rtl/range_reader_if.sv
// Result stream from range_reader: one (n, count) beat per RAM word, valid/ready handshake.
interface range_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_n;
    logic [15:0] out_count;
    logic        out_last;

    modport master (
        output out_valid,
        output out_n,
        output out_count,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_n,
        input  out_count,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/range_reader.sv
// Host-side controller for the Collatz range engine: starts a run, waits for done,
// then streams every RAM word back as (n, count) beats while tracking the max count.
module range_reader #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [31:0]        base,
    output logic               busy,
    output logic               rgo,
    output logic [31:0]        rstart,
    input  logic               rdone,
    input  logic [15:0]        rcount,
    range_reader_if.master     out_if,
    output logic [15:0]        max_count,
    output logic [31:0]        max_n,
    output logic               summary_valid,
    output logic [31:0]        run_cycles
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ADDR   = 3'd4;
    localparam logic [2:0] S_CAPT   = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    logic [2:0]               state;
    logic [31:0]              base_q;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic                     out_valid_q;
    logic [31:0]              out_n_q;
    logic [15:0]              out_count_q;
    logic                     out_last_q;
    logic [31:0]              cur_n;

    assign cur_n = base_q + 32'(idx);

    // go and start are decoded from state so go can only ever appear in START.
    always_comb begin
        rgo    = 1'b0;
        rstart = '0;
        case (state)
            S_START: begin
                rgo    = 1'b1;
                rstart = base_q;
            end
            S_ADDR:  rstart = {{(32-RAM_ADDR_BITS){1'b0}}, idx};
            default: ;
        endcase
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_n     = out_n_q;
    assign out_if.out_count = out_count_q;
    assign out_if.out_last  = out_last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            base_q        <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            out_valid_q   <= 1'b0;
            out_n_q       <= '0;
            out_count_q   <= '0;
            out_last_q    <= 1'b0;
            max_count     <= '0;
            max_n         <= '0;
            summary_valid <= 1'b0;
            run_cycles    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        base_q        <= base;
                        idx           <= '0;
                        max_count     <= '0;
                        max_n         <= '0;
                        run_cycles    <= '0;
                        summary_valid <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START:  state <= S_SETTLE;
                // range drops a stale done on the edge that samples go; skip one cycle.
                S_SETTLE: state <= S_WAIT;
                S_WAIT: begin
                    if (run_cycles != '1)
                        run_cycles <= run_cycles + 32'd1;
                    if (rdone)
                        state <= S_ADDR;
                end
                S_ADDR:   state <= S_CAPT;
                S_CAPT: begin
                    out_count_q <= rcount;
                    out_n_q     <= cur_n;
                    out_last_q  <= (idx == LAST_IDX);
                    out_valid_q <= 1'b1;
                    // strict compare: ties keep the lowest index
                    if (rcount > max_count) begin
                        max_count <= rcount;
                        max_n     <= cur_n;
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            busy          <= 1'b0;
                            summary_valid <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_ADDR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_reader.sv
// Directed bench for range_reader against a behavioural stub of the range engine.
module tb_range_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] base = '0;
    logic        busy, rgo;
    logic [31:0] rstart;
    logic        rdone = 1'b0;
    logic [15:0] rcount = '0;
    logic [15:0] max_count;
    logic [31:0] max_n;
    logic        summary_valid;
    logic [31:0] run_cycles;

    range_reader_if rif();

    range_reader #(.RAM_WORDS(16), .RAM_ADDR_BITS(4)) dut (
        .clk(clk), .reset(reset), .req(req), .base(base), .busy(busy),
        .rgo(rgo), .rstart(rstart), .rdone(rdone), .rcount(rcount),
        .out_if(rif.master), .max_count(max_count), .max_n(max_n),
        .summary_valid(summary_valid), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // range stub: count = 100+addr (mode 0) or 7 (mode 1); done rises 'delay' cycles into WAIT
    int mode = 0;
    int delay = 5;
    int dly_cnt = 0;
    always @(posedge clk) begin
        rcount <= (mode == 0) ? 16'(100 + int'(rstart[3:0])) : 16'd7;
        if (rgo) begin
            rdone   <= 1'b0;
            dly_cnt <= 1;
        end else if (dly_cnt != 0) begin
            if (dly_cnt == delay) begin
                rdone   <= 1'b1;
                dly_cnt <= 0;
            end else
                dly_cnt <= dly_cnt + 1;
        end
    end

    int          rgo_cnt = 0;
    logic [31:0] rgo_start = '0;
    always @(posedge clk) begin
        if (rgo === 1'b1) begin
            rgo_cnt   = rgo_cnt + 1;
            rgo_start = rstart;
        end
    end

    logic [31:0] bn [16];
    logic [15:0] bc [16];
    logic        bl [16];

    task automatic do_run(input logic [31:0] b, input int pct, input bit spam,
                          output int nb, output bit tmo, output int stall_bad);
        bit          prev, got_last;
        logic [31:0] hn;
        logic [15:0] hc;
        logic        hl;
        nb = 0; tmo = 1'b1; stall_bad = 0; prev = 1'b0; got_last = 1'b0;
        hn = '0; hc = '0; hl = 1'b0;
        @(negedge clk);
        base = b; req = 1'b1; rif.out_ready = 1'b0;
        @(negedge clk);
        req = spam; base = 32'hDEAD_0000;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (prev && (rif.out_valid !== 1'b1 || rif.out_n !== hn ||
                         rif.out_count !== hc || rif.out_last !== hl))
                stall_bad++;
            rif.out_ready = ($urandom_range(99) < pct);
            if (rif.out_valid && rif.out_ready) begin
                if (nb < 16) begin
                    bn[nb] = rif.out_n; bc[nb] = rif.out_count; bl[nb] = rif.out_last;
                end
                nb++;
                prev = 1'b0;
                if (rif.out_last) got_last = 1'b1;
            end else begin
                prev = rif.out_valid;
                hn = rif.out_n; hc = rif.out_count; hl = rif.out_last;
            end
            req = spam && !got_last;
            if (got_last) begin
                @(negedge clk);
                tmo = 1'b0;
                break;
            end
        end
        req = 1'b0;
        rif.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rgo, rstart, rif.out_valid, rif.out_n, rif.out_count, rif.out_last,
             max_count, max_n, summary_valid, run_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rgo=%b rstart=%h valid=%b n=%h cnt=%h max=%h sv=%b rc=%h, required all zero",
                     busy, rgo, rstart, rif.out_valid, rif.out_n, rif.out_count, max_count, summary_valid, run_cycles);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int nb, sb, r0; bit tmo;
        mode = 0; delay = 5; r0 = rgo_cnt;
        do_run(32'd1, 100, 1'b0, nb, tmo, sb);
        checks++;
        if (tmo !== 1'b0 || nb != 16) begin
            errors++; $display("FAIL basic_beats: tmo=%b beats=%0d, required tmo=0 beats=16", tmo, nb);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bn[i] !== 32'(1 + i) || bc[i] !== 16'(100 + i) || bl[i] !== (i == 15)) begin
                errors++;
                $display("FAIL basic_beat%0d: n=%0d cnt=%0d last=%b, required n=%0d cnt=%0d last=%b",
                         i, bn[i], bc[i], bl[i], 1 + i, 100 + i, (i == 15));
            end
        end
        checks++;
        if (max_count !== 16'd115 || max_n !== 32'd16) begin
            errors++; $display("FAIL basic_max: max=%0d n=%0d, required 115/16", max_count, max_n);
        end
        checks++;
        if (summary_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_summary: sv=%b busy=%b, required 1/0", summary_valid, busy);
        end
        checks++;
        if (run_cycles !== 32'd5) begin
            errors++; $display("FAIL basic_run_cycles: %0d, required 5", run_cycles);
        end
        checks++;
        if (rgo_cnt - r0 != 1 || rgo_start !== 32'd1) begin
            errors++; $display("FAIL basic_rgo: pulses=%0d start=%0d, required 1/1", rgo_cnt - r0, rgo_start);
        end
    endtask

    task automatic test_tie;
        int nb, sb, r0; bit tmo;
        mode = 1; delay = 5; r0 = rgo_cnt;
        do_run(32'd50, 100, 1'b0, nb, tmo, sb);
        checks++;
        if (tmo !== 1'b0 || nb != 16 || bc[3] !== 16'd7 || bn[15] !== 32'd65) begin
            errors++; $display("FAIL tie_beats: tmo=%b beats=%0d cnt3=%0d n15=%0d, required 0/16/7/65", tmo, nb, bc[3], bn[15]);
        end
        checks++;
        if (max_count !== 16'd7 || max_n !== 32'd50) begin
            errors++; $display("FAIL tie_max: max=%0d n=%0d, required 7/50", max_count, max_n);
        end
        checks++;
        if (rgo_cnt - r0 != 1 || rgo_start !== 32'd50) begin
            errors++; $display("FAIL tie_rgo: pulses=%0d start=%0d, required 1/50", rgo_cnt - r0, rgo_start);
        end
        mode = 0;
    endtask

    task automatic test_stall;
        int nb, sb, r0, bad; bit tmo;
        mode = 0; delay = 5; r0 = rgo_cnt; bad = 0;
        do_run(32'd1, 30, 1'b0, nb, tmo, sb);
        checks++;
        if (tmo !== 1'b0 || nb != 16) begin
            errors++; $display("FAIL stall_beats: tmo=%b beats=%0d, required 0/16", tmo, nb);
        end
        for (int i = 0; i < 16; i++)
            if (bn[i] !== 32'(1 + i) || bc[i] !== 16'(100 + i) || bl[i] !== (i == 15)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_data: %0d wrong beats, required 0", bad);
        end
        checks++;
        if (sb != 0) begin
            errors++; $display("FAIL stall_hold: %0d unstable stalled cycles, required 0", sb);
        end
        checks++;
        if (rgo_cnt - r0 != 1 || max_count !== 16'd115) begin
            errors++; $display("FAIL stall_rgo_max: pulses=%0d max=%0d, required 1/115", rgo_cnt - r0, max_count);
        end
    endtask

    task automatic test_wrap;
        int nb, sb; bit tmo;
        logic [31:0] exp_n;
        mode = 0; delay = 40;
        do_run(32'hFFFF_FFF8, 100, 1'b0, nb, tmo, sb);
        checks++;
        if (tmo !== 1'b0 || nb != 16) begin
            errors++; $display("FAIL wrap_beats: tmo=%b beats=%0d, required 0/16", tmo, nb);
        end
        for (int i = 0; i < 16; i++) begin
            exp_n = (i < 8) ? 32'hFFFF_FFF8 + 32'(i) : 32'(i - 8);
            checks++;
            if (bn[i] !== exp_n) begin
                errors++; $display("FAIL wrap_n%0d: %h, required %h", i, bn[i], exp_n);
            end
        end
        checks++;
        if (run_cycles !== 32'd40 || max_n !== 32'd7) begin
            errors++; $display("FAIL wrap_summary: rc=%0d max_n=%0d, required 40/7", run_cycles, max_n);
        end
        delay = 5;
    endtask

    task automatic test_req_ignored;
        int nb, sb, r0; bit tmo;
        mode = 0; delay = 5; r0 = rgo_cnt;
        do_run(32'd20, 100, 1'b1, nb, tmo, sb);
        checks++;
        if (tmo !== 1'b0 || nb != 16 || bn[0] !== 32'd20 || bn[15] !== 32'd35) begin
            errors++; $display("FAIL reqign_beats: tmo=%b beats=%0d n0=%0d n15=%0d, required 0/16/20/35", tmo, nb, bn[0], bn[15]);
        end
        checks++;
        if (rgo_cnt - r0 != 1 || max_n !== 32'd35 || run_cycles !== 32'd5) begin
            errors++; $display("FAIL reqign_rgo: pulses=%0d max_n=%0d rc=%0d, required 1/35/5", rgo_cnt - r0, max_n, run_cycles);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || summary_valid !== 1'b1 || rgo_cnt - r0 != 1) begin
            errors++; $display("FAIL reqign_idle: busy=%b sv=%b pulses=%0d, required 0/1/1", busy, summary_valid, rgo_cnt - r0);
        end
    endtask

    task automatic test_reset_mid;
        int nb, sb, r0; bit tmo, found;
        mode = 0; delay = 5; found = 1'b0;
        @(negedge clk);
        base = 32'd9; req = 1'b1; rif.out_ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || summary_valid !== 1'b0) begin
            errors++; $display("FAIL newreq_clears: busy=%b sv=%b, required 1/0", busy, summary_valid);
        end
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (rif.out_valid === 1'b1 && rif.out_n === 32'd13) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midreset_reach: beat 5 seen=%b, required 1", found);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, rgo, rstart, rif.out_valid, rif.out_n, rif.out_count, rif.out_last,
             max_count, max_n, summary_valid, run_cycles} !== '0) begin
            errors++;
            $display("FAIL midreset_zero: busy=%b rgo=%b valid=%b n=%h cnt=%h max=%h max_n=%h rc=%h, required all zero",
                     busy, rgo, rif.out_valid, rif.out_n, rif.out_count, max_count, max_n, run_cycles);
        end
        @(negedge clk);
        reset = 1'b0;
        r0 = rgo_cnt;
        do_run(32'd3, 100, 1'b0, nb, tmo, sb);
        checks++;
        if (tmo !== 1'b0 || nb != 16 || bn[0] !== 32'd3 || bc[0] !== 16'd100 || bl[15] !== 1'b1) begin
            errors++; $display("FAIL postreset_run: tmo=%b beats=%0d n0=%0d c0=%0d, required 0/16/3/100", tmo, nb, bn[0], bc[0]);
        end
        checks++;
        if (rgo_cnt - r0 != 1 || max_n !== 32'd18 || max_count !== 16'd115) begin
            errors++; $display("FAIL postreset_summary: pulses=%0d max_n=%0d max=%0d, required 1/18/115", rgo_cnt - r0, max_n, max_count);
        end
    endtask

    initial begin
        rif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_stall();
        test_wrap();
        test_req_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
